// File: rtl/zx81_pkg.sv
// Shared types for the ZX81 RAM arbiter: requester identity, arbiter FSM states,
// and the read latency of the synchronous system RAM.
package zx81_pkg;
  typedef enum logic [1:0] {NONE, CPU, LDR} owner_t;
  typedef enum logic [1:0] {SHARE, DRAIN, HOLD, RELEASE} arb_state_t;
  localparam int RAM_RD_LATENCY = 1;
endpackage

// File: rtl/zx81_starve_timer.sv
// Saturating count of consecutive cycles the loader was kept waiting.
module zx81_starve_timer #(
  parameter int MAX = 8,
  parameter int W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)             cnt <= '0;
    else if (inc && !at_max)      cnt <= cnt + W'(1);
  end

  assign at_max = (cnt == W'(MAX));
endmodule

// File: rtl/zx81_ram_arbiter.sv
// Shares the single synchronous system RAM between the Z80 and the loader port.
// CPU has priority in SHARE; HOLD gives the loader exclusive access with the CPU stalled.
module zx81_ram_arbiter
  import zx81_pkg::*;
#(
  parameter int AW         = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          ldr_valid,
  output logic          ldr_ready,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_a,
  input  logic [7:0]    ldr_wdata,
  output logic [7:0]    ldr_rdata,
  output logic          ldr_rvalid,
  input  logic          ldr_hold,
  output logic          ldr_held,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);
  arb_state_t state, state_nxt;
  owner_t     grant, rd_grant, owner_q;
  owner_t     owner_pipe [RAM_RD_LATENCY];
  logic       at_max;

  zx81_starve_timer #(.MAX(STARVE_MAX), .W(8)) u_starve (
    .clk    (clk_sys),
    .reset  (reset),
    .inc    (ldr_valid & ~ldr_ready),
    .clr    (~ldr_valid | ldr_ready),
    .at_max (at_max)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= SHARE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = NONE;
    cpu_wait_n = 1'b1;
    ldr_held   = 1'b0;
    case (state)
      SHARE: begin
        // A starved loader steals the slot; the stalled CPU re-presents its cycle.
        if (at_max && ldr_valid) begin
          grant      = LDR;
          cpu_wait_n = 1'b0;
        end else if (cpu_req)   grant = CPU;
        else if (ldr_valid)     grant = LDR;
        if (ldr_hold) state_nxt = DRAIN;
      end
      DRAIN: begin
        cpu_wait_n = 1'b0;
        if (ldr_valid) grant = LDR;
        state_nxt = ldr_hold ? HOLD : RELEASE;
      end
      HOLD: begin
        cpu_wait_n = 1'b0;
        ldr_held   = 1'b1;
        if (ldr_valid) grant = LDR;
        if (!ldr_hold) state_nxt = RELEASE;
      end
      RELEASE: begin
        cpu_wait_n = 1'b0;
        state_nxt  = SHARE;
      end
      default: state_nxt = SHARE;
    endcase
    if (reset) begin
      grant      = NONE;
      cpu_wait_n = 1'b1;
      ldr_held   = 1'b0;
    end
  end

  assign ldr_ready = (grant == LDR);

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_a     = '0;
    ram_wdata = '0;
    rd_grant  = NONE;
    case (grant)
      CPU: begin
        ram_ce    = 1'b1;
        ram_we    = cpu_we;
        ram_a     = cpu_a;
        ram_wdata = cpu_wdata;
        if (!cpu_we) rd_grant = CPU;
      end
      LDR: begin
        ram_ce    = 1'b1;
        ram_we    = ldr_we;
        ram_a     = ldr_a;
        ram_wdata = ldr_wdata;
        if (!ldr_we) rd_grant = LDR;
      end
      default: ;
    endcase
  end

  // Tracks who owns the read data emerging from the RAM, one entry per latency cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < RAM_RD_LATENCY; i++) owner_pipe[i] <= NONE;
    end else begin
      owner_pipe[0] <= rd_grant;
      for (int i = 1; i < RAM_RD_LATENCY; i++) owner_pipe[i] <= owner_pipe[i-1];
    end
  end

  assign owner_q = owner_pipe[RAM_RD_LATENCY-1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_rdata  <= 8'hFF;
      ldr_rdata  <= 8'h00;
      ldr_rvalid <= 1'b0;
    end else begin
      ldr_rvalid <= (owner_q == LDR);
      if (owner_q == CPU) cpu_rdata <= ram_rdata;
      if (owner_q == LDR) ldr_rdata <= ram_rdata;
    end
  end
endmodule
